aes_key_sched: RTL and testbench

//  Iterative AES-128 key expansion that produces the round keys for the encrypt datapath.
//  - Expands one 128-bit cipher key into round keys rk[0..10] and holds them in an internal register file.
//  - Serves any round key through a registered read port; the last-round stage reads rk[10] on its rkey input.
//  - SubWord reuses the team's sub_bytes instance: registered, 1-cycle latency.

---
 rtl/aes_key_sched.sv | 193 +++++++++++++++++++
 tb/tb_aes_key_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion with an 11-entry round-key register file and a registered read port.
// Optional build macro AES_KSCHED_REVERSE_EN: the read port serves round keys in decrypt order.

module sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(11'd2047 - {b, 3'b000}) -: 8];
    endfunction

    logic [127:0] data_d;
    logic [127:0] data_q;

    always_comb begin
        data_d = '0;
        for (int i = 0; i < 16; i++) begin
            data_d[8*i +: 8] = sbox(data_i[8*i +: 8]);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

module aes_key_sched #(
    parameter int NR    = 10,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     key_in,
    input  logic             key_load,
    output logic             key_busy,
    output logic             key_ready,
    input  logic [SEL_W-1:0] rkey_sel,
    output logic [127:0]     rkey
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        XOR  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0]       NR_CNT  = 4'(NR);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NR);

    state_e       state_q, state_d;
    logic [127:0] w_q, w_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         busy_q, busy_d;
    logic         ready_q, ready_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] rk_q [0:NR];

    logic         rk_we;
    logic [3:0]   rk_waddr;
    logic [127:0] rk_wdata;

    logic [127:0] sbox_in;
    logic [127:0] sbox_out;
    logic [31:0]  t, w0, w1, w2, w3;
    logic [7:0]   rcon_x;
    logic [SEL_W-1:0] rd_idx;

    // SubWord of RotWord(w3); only the top word of the shared instance carries data.
    assign sbox_in = {w_q[23:0], w_q[31:24], 96'h0};

    sub_bytes u_sub_bytes (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (sbox_in),
        .data_o (sbox_out)
    );

    always_comb begin
        t      = sbox_out[127:96] ^ {rcon_q, 24'h0};
        w0     = w_q[127:96] ^ t;
        w1     = w_q[95:64]  ^ w0;
        w2     = w_q[63:32]  ^ w1;
        w3     = w_q[31:0]   ^ w2;
        rcon_x = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        rcon_d   = rcon_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        rk_we    = 1'b0;
        rk_waddr = cnt_q;
        rk_wdata = {w0, w1, w2, w3};
        case (state_q)
            IDLE, DONE: begin
                if (key_load) begin
                    rk_we    = 1'b1;
                    rk_waddr = 4'd0;
                    rk_wdata = key_in;
                    w_d      = key_in;
                    cnt_d    = 4'd1;
                    rcon_d   = 8'h01;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = SUB;
                end
            end
            SUB: state_d = XOR;
            XOR: begin
                rk_we  = 1'b1;
                w_d    = {w0, w1, w2, w3};
                rcon_d = rcon_x;
                if (cnt_q == NR_CNT) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = SUB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef AES_KSCHED_REVERSE_EN
        rd_idx = SEL_MAX - rkey_sel;
`else
        rd_idx = rkey_sel;
`endif
        rkey_d = (rkey_sel <= SEL_MAX) ? rk_q[rd_idx] : 128'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            rkey_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            rkey_q  <= rkey_d;
        end
    end

    // NOTE: the round-key file is cleared on reset so stale keys never leak out of the read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else if (rk_we) begin
            rk_q[rk_waddr] <= rk_wdata;
        end
    end

    assign key_busy  = busy_q;
    assign key_ready = ready_q;
    assign rkey      = rkey_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 and all-zero key vectors plus load/reset corner sequences.
// Honours AES_KSCHED_REVERSE_EN when mapping round-key indices to read selects.

module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         key_busy;
    logic         key_ready;
    logic [3:0]   rkey_sel = '0;
    logic [127:0] rkey;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_Z = 128'h0;

    aes_key_sched #(.NR(10), .SEL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_load  (key_load),
        .key_busy  (key_busy),
        .key_ready (key_ready),
        .rkey_sel  (rkey_sel),
        .rkey      (rkey)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sel_for(input int idx);
`ifdef AES_KSCHED_REVERSE_EN
        if (idx <= 10) return 4'(10 - idx);
`endif
        return 4'(idx);
    endfunction

    task automatic read_rk(input int idx, output logic [127:0] got);
        rkey_sel = sel_for(idx);
        tick();
        got = rkey;
    endtask

    task automatic pulse_load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("load_busy", 128'(key_busy), 128'd1);
        check("load_ready_low", 128'(key_ready), 128'd0);
    endtask

    task automatic wait_ready(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (key_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        vec_t         vecs[$];
        logic [127:0] got;
        logic [127:0] cur_key;
        bit           loaded;
        int           lat;

        vecs.push_back('{KEY_A, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
        vecs.push_back('{KEY_A, 1,  128'ha0fafe1788542cb123a339392a6c7605});
        vecs.push_back('{KEY_A, 2,  128'hf2c295f27a96b9435935807a7359f67f});
        vecs.push_back('{KEY_A, 3,  128'h3d80477d4716fe3e1e237e446d7a883b});
        vecs.push_back('{KEY_A, 4,  128'hef44a541a8525b7fb671253bdb0bad00});
        vecs.push_back('{KEY_A, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc});
        vecs.push_back('{KEY_A, 6,  128'h6d88a37a110b3efddbf98641ca0093fd});
        vecs.push_back('{KEY_A, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f});
        vecs.push_back('{KEY_A, 8,  128'head27321b58dbad2312bf5607f8d292f});
        vecs.push_back('{KEY_A, 9,  128'hac7766f319fadc2128d12941575c006e});
        vecs.push_back('{KEY_A, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        for (int s = 11; s <= 15; s++) vecs.push_back('{KEY_A, s, 128'h0});
        vecs.push_back('{KEY_Z, 0,  128'h0});
        vecs.push_back('{KEY_Z, 1,  128'h62636363626363636263636362636363});
        vecs.push_back('{KEY_Z, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
        vecs.push_back('{KEY_Z, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});

        // Reset held for two clocks, then every select reads zero.
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", 128'(key_busy), 128'd0);
        check("rst_ready", 128'(key_ready), 128'd0);
        check("rst_rkey", rkey, 128'h0);
        rst_n = 1'b1;
        for (int s = 0; s < 16; s++) begin
            rkey_sel = 4'(s);
            tick();
            check($sformatf("rst_sel%0d", s), rkey, 128'h0);
        end

        // Table-driven vectors; a new key triggers a load and a latency check.
        loaded  = 1'b0;
        cur_key = '0;
        foreach (vecs[i]) begin
            if (!loaded || vecs[i].key !== cur_key) begin
                pulse_load(vecs[i].key);
                wait_ready(lat);
                check("ready_latency", 128'(lat), 128'd20);
                cur_key = vecs[i].key;
                loaded  = 1'b1;
            end
            read_rk(vecs[i].idx, got);
            check($sformatf("vec%0d_rk%0d", i, vecs[i].idx), got, vecs[i].exp);
        end

        // Load of the zero key arrives at edge 5 of the key A expansion and must be ignored.
        pulse_load(KEY_A);
        repeat (4) tick();
        key_in   = KEY_Z;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("ign_busy", 128'(key_busy), 128'd1);
        wait_ready(lat);
        check("ign_latency", 128'(lat), 128'd15);
        read_rk(10, got);
        check("ign_rk10", got, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(1, got);
        check("ign_rk1", got, 128'ha0fafe1788542cb123a339392a6c7605);

        // Restart from DONE with the zero key.
        pulse_load(KEY_Z);
        wait_ready(lat);
        check("restart_latency", 128'(lat), 128'd20);
        read_rk(1, got);
        check("restart_rk1", got, 128'h62636363626363636263636362636363);
        read_rk(10, got);
        check("restart_rk10", got, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // One-clock reset at edge 7 of an expansion.
        pulse_load(KEY_A);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", 128'(key_busy), 128'd0);
        check("mid_rst_ready", 128'(key_ready), 128'd0);
        check("mid_rst_rkey", rkey, 128'h0);
        read_rk(0, got);
        check("mid_rst_rk0", got, 128'h0);
        read_rk(1, got);
        check("mid_rst_rk1", got, 128'h0);
        repeat (3) tick();
        check("mid_rst_idle", 128'(key_busy), 128'd0);
        pulse_load(KEY_A);
        wait_ready(lat);
        check("fresh_latency", 128'(lat), 128'd20);
        read_rk(1, got);
        check("fresh_rk1", got, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(10, got);
        check("fresh_rk10", got, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(0, got);
        check("fresh_rk0", got, KEY_A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
